// File: rtl/fdma_bram_slave.sv
// FDMA responder backed by a single-port block RAM; serves one write or read burst at a time.
// Optional statistics counters exist only when FDMA_SLV_STATS_EN is defined.
module fdma_bram_slave #(
  parameter int DATA_W   = 128,
  parameter int AW       = 12,
  parameter int BYTE_LSB = 4
) (
  input  logic              ui_clk,
  input  logic              ui_rst,
  input  logic [31:0]       fdma_waddr,
  input  logic              fdma_wareq,
  input  logic [15:0]       fdma_wsize,
  output logic              fdma_wbusy,
  output logic              fdma_wvalid,
  input  logic              fdma_wready,
  input  logic [DATA_W-1:0] fdma_wdata,
  input  logic [31:0]       fdma_raddr,
  input  logic              fdma_rareq,
  input  logic [15:0]       fdma_rsize,
  output logic              fdma_rbusy,
  output logic              fdma_rvalid,
  input  logic              fdma_rready,
  output logic [DATA_W-1:0] fdma_rdata
`ifdef FDMA_SLV_STATS_EN
  ,
  output logic [31:0]       stat_wr_bursts,
  output logic [31:0]       stat_rd_bursts,
  output logic [31:0]       stat_beats
`endif
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [15:0]       beats_left;
  logic [15:0]       reads_left;
  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rd_q;
  logic              in_flight;
  logic [DATA_W-1:0] fifo_data [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              issue;
  logic              pop;
  logic              fifo_pop;
  logic              push;
  logic              addr_unused;

  assign addr_unused = &{1'b0, fdma_waddr, fdma_raddr};

  assign fdma_wvalid = (state == WR) && (beats_left != 16'd0) && fdma_wready;

  // A read in flight is presented straight from the RAM output so the first beat
  // appears two cycles after the request; it only lands in the buffer when stalled.
  assign issue       = (state == RD) && (reads_left != 16'd0) && ((count + {1'b0, in_flight}) < 2'd2);
  assign fdma_rvalid = (count != 2'd0) || in_flight;
  assign fdma_rdata  = (count != 2'd0) ? fifo_data[rd_ptr] : (in_flight ? rd_q : '0);
  assign pop         = fdma_rvalid && fdma_rready;
  assign fifo_pop    = fdma_rready && (count != 2'd0);
  assign push        = in_flight && !((count == 2'd0) && fdma_rready);

  always_ff @(posedge ui_clk) begin
    if (fdma_wvalid) mem[idx] <= fdma_wdata;
    if (issue) rd_q <= mem[idx];
    if (push) fifo_data[wr_ptr] <= rd_q;
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state      <= IDLE;
      fdma_wbusy <= 1'b0;
      fdma_rbusy <= 1'b0;
      idx        <= '0;
      beats_left <= '0;
      reads_left <= '0;
      in_flight  <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      in_flight <= issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      case ({push, fifo_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (fdma_wareq) begin
            idx        <= fdma_waddr[BYTE_LSB +: AW];
            beats_left <= fdma_wsize;
            fdma_wbusy <= 1'b1;
            state      <= WR;
          end else if (fdma_rareq) begin
            idx        <= fdma_raddr[BYTE_LSB +: AW];
            beats_left <= fdma_rsize;
            reads_left <= fdma_rsize;
            fdma_rbusy <= 1'b1;
            state      <= RD;
          end
        end
        WR: begin
          if (beats_left == 16'd0) begin
            fdma_wbusy <= 1'b0;
            state      <= DONE;
          end else if (fdma_wvalid) begin
            idx        <= idx + AW'(1);
            beats_left <= beats_left - 16'd1;
            if (beats_left == 16'd1) begin
              fdma_wbusy <= 1'b0;
              state      <= DONE;
            end
          end
        end
        RD: begin
          if (issue) begin
            idx        <= idx + AW'(1);
            reads_left <= reads_left - 16'd1;
          end
          if (beats_left == 16'd0) begin
            fdma_rbusy <= 1'b0;
            state      <= DONE;
          end else if (pop) begin
            beats_left <= beats_left - 16'd1;
            if (beats_left == 16'd1) begin
              fdma_rbusy <= 1'b0;
              state      <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FDMA_SLV_STATS_EN
  logic last_wr;

  // Burst counters tick once in DONE, so zero-length bursts are counted too.
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      last_wr        <= 1'b0;
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
      stat_beats     <= '0;
    end else begin
      if (state == IDLE) last_wr <= fdma_wareq;
      if (state == DONE) begin
        if (last_wr) begin
          if (stat_wr_bursts != '1) stat_wr_bursts <= stat_wr_bursts + 32'd1;
        end else begin
          if (stat_rd_bursts != '1) stat_rd_bursts <= stat_rd_bursts + 32'd1;
        end
      end
      if ((fdma_wvalid || pop) && (stat_beats != '1)) stat_beats <= stat_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fdma_bram_slave.sv
// Directed self-checking bench for fdma_bram_slave: bursts, wrap, backpressure,
// write throttling, request priority, zero-length bursts and reset mid-read.
module tb_fdma_bram_slave;

  logic         ui_clk;
  logic         ui_rst;
  logic [31:0]  fdma_waddr;
  logic         fdma_wareq;
  logic [15:0]  fdma_wsize;
  logic         fdma_wbusy;
  logic         fdma_wvalid;
  logic         fdma_wready;
  logic [127:0] fdma_wdata;
  logic [31:0]  fdma_raddr;
  logic         fdma_rareq;
  logic [15:0]  fdma_rsize;
  logic         fdma_rbusy;
  logic         fdma_rvalid;
  logic         fdma_rready;
  logic [127:0] fdma_rdata;

  int checks;
  int failures;
  logic [127:0] wvec [1024];
  logic [127:0] rexp [1024];

  fdma_bram_slave dut (
    .ui_clk      (ui_clk),
    .ui_rst      (ui_rst),
    .fdma_waddr  (fdma_waddr),
    .fdma_wareq  (fdma_wareq),
    .fdma_wsize  (fdma_wsize),
    .fdma_wbusy  (fdma_wbusy),
    .fdma_wvalid (fdma_wvalid),
    .fdma_wready (fdma_wready),
    .fdma_wdata  (fdma_wdata),
    .fdma_raddr  (fdma_raddr),
    .fdma_rareq  (fdma_rareq),
    .fdma_rsize  (fdma_rsize),
    .fdma_rbusy  (fdma_rbusy),
    .fdma_rvalid (fdma_rvalid),
    .fdma_rready (fdma_rready),
    .fdma_rdata  (fdma_rdata)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one write burst from wvec; request cycle is cycle 0, inputs change 1ns after each edge.
  task automatic applyWrite(input logic [31:0] addr, input int size, input int stallAt,
                            input int stallLen, input bit withRead, input string tag);
    int beats = 0;
    int fallCyc = -1;
    int busyCycles = 0;
    int stallViol = 0;
    int stalled = 0;
    int rbusyHigh = 0;
    bit seenBusy = 1'b0;
    bit busyAt1 = 1'b0;
    @(posedge ui_clk); #1;
    fdma_waddr  = addr;
    fdma_wsize  = 16'(size);
    fdma_wareq  = 1'b1;
    fdma_wready = 1'b1;
    fdma_wdata  = wvec[0];
    if (withRead) fdma_rareq = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge ui_clk); #1;
      if (fdma_wbusy) fdma_wareq = 1'b0;
      if (beats == stallAt && stalled < stallLen) begin
        fdma_wready = 1'b0;
        stalled++;
      end else begin
        fdma_wready = 1'b1;
      end
      fdma_wdata = (beats < 1024) ? wvec[beats] : '0;
      @(negedge ui_clk);
      if (cyc == 1) busyAt1 = fdma_wbusy;
      if (fdma_wbusy) busyCycles++;
      if (fdma_rbusy) rbusyHigh++;
      if (fdma_wvalid && !fdma_wready) stallViol++;
      if (fdma_wvalid) beats++;
      if (seenBusy && !fdma_wbusy) begin
        fallCyc = cyc;
        break;
      end
      if (fdma_wbusy) seenBusy = 1'b1;
    end
    fdma_wareq  = 1'b0;
    fdma_wready = 1'b0;
    checkOutput({tag, "_busy_t1"}, 128'(busyAt1), 128'd1);
    checkOutput({tag, "_beats"}, 128'(beats), 128'(size));
    checkOutput({tag, "_wvalid_no_wready"}, 128'(stallViol), 128'd0);
    checkOutput({tag, "_busy_cycles"}, 128'(busyCycles), 128'((size == 0) ? 1 : size + stalled));
    checkOutput({tag, "_fall_cycle"}, 128'(fallCyc), 128'((size == 0) ? 2 : size + stalled + 1));
    checkOutput({tag, "_rbusy_during_wr"}, 128'(rbusyHigh), 128'd0);
  endtask

  // Runs one read burst checked against rexp; toggle applies a 0,0,1,1 rready pattern,
  // abortAt>=0 pulses ui_rst once that many beats have transferred.
  task automatic applyRead(input logic [31:0] addr, input int size, input bit toggle,
                           input int abortAt, input string tag);
    int beats = 0;
    int fallCyc = -1;
    int lastBeat = -1;
    int busyCycles = 0;
    int firstValid = -1;
    int dataErr = 0;
    int holdErr = 0;
    bit seenBusy = 1'b0;
    bit prevStall = 1'b0;
    bit aborted = 1'b0;
    logic [127:0] prevData = '0;
    @(posedge ui_clk); #1;
    fdma_raddr  = addr;
    fdma_rsize  = 16'(size);
    fdma_rareq  = 1'b1;
    fdma_rready = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge ui_clk); #1;
      if (fdma_rbusy) fdma_rareq = 1'b0;
      if (abortAt >= 0 && beats == abortAt) begin
        aborted = 1'b1;
        break;
      end
      fdma_rready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge ui_clk);
      if (fdma_rbusy) busyCycles++;
      if (fdma_rvalid && firstValid < 0) firstValid = cyc;
      if (prevStall && (!fdma_rvalid || fdma_rdata !== prevData)) holdErr++;
      if (fdma_rvalid && fdma_rready) begin
        if (beats >= 1024 || fdma_rdata !== rexp[beats]) dataErr++;
        beats++;
        lastBeat = cyc;
      end
      prevStall = fdma_rvalid && !fdma_rready;
      prevData  = fdma_rdata;
      if (seenBusy && !fdma_rbusy) begin
        fallCyc = cyc;
        break;
      end
      if (fdma_rbusy) seenBusy = 1'b1;
    end
    fdma_rareq  = 1'b0;
    fdma_rready = 1'b0;
    checkOutput({tag, "_data_errors"}, 128'(dataErr), 128'd0);
    checkOutput({tag, "_hold_errors"}, 128'(holdErr), 128'd0);
    if (aborted || abortAt >= 0) begin
      checkOutput({tag, "_reached_abort"}, 128'(aborted), 128'd1);
      ui_rst = 1'b1;
      @(posedge ui_clk); #1;
      ui_rst = 1'b0;
      @(negedge ui_clk);
      checkOutput({tag, "_rvalid_after_rst"}, 128'(fdma_rvalid), 128'd0);
      checkOutput({tag, "_rbusy_after_rst"}, 128'(fdma_rbusy), 128'd0);
      checkOutput({tag, "_rdata_after_rst"}, fdma_rdata, 128'd0);
    end else begin
      checkOutput({tag, "_beats"}, 128'(beats), 128'(size));
      checkOutput({tag, "_first_rvalid"}, 128'(firstValid), (size == 0) ? '1 : 128'd2);
      if (toggle) begin
        checkOutput({tag, "_fall_after_last"}, 128'(fallCyc - lastBeat), 128'd1);
      end else begin
        checkOutput({tag, "_fall_cycle"}, 128'(fallCyc), 128'((size == 0) ? 2 : size + 2));
      end
      if (size == 0) checkOutput({tag, "_busy_cycles"}, 128'(busyCycles), 128'd1);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    ui_rst      = 1'b1;
    fdma_waddr  = '0;
    fdma_wareq  = 1'b0;
    fdma_wsize  = '0;
    fdma_wready = 1'b1;
    fdma_wdata  = '0;
    fdma_raddr  = '0;
    fdma_rareq  = 1'b0;
    fdma_rsize  = '0;
    fdma_rready = 1'b1;
    repeat (3) @(posedge ui_clk);
    @(negedge ui_clk);
    checkOutput("rst_wbusy", 128'(fdma_wbusy), 128'd0);
    checkOutput("rst_rbusy", 128'(fdma_rbusy), 128'd0);
    checkOutput("rst_wvalid", 128'(fdma_wvalid), 128'd0);
    checkOutput("rst_rvalid", 128'(fdma_rvalid), 128'd0);
    checkOutput("rst_rdata", fdma_rdata, 128'd0);
    #1;
    ui_rst      = 1'b0;
    fdma_wready = 1'b0;
    fdma_rready = 1'b0;
    @(negedge ui_clk);

    $display("[TB] 512-beat write then read at address 0");
    for (int i = 0; i < 512; i++) wvec[i] = 128'(i);
    applyWrite(32'h0, 512, -1, 0, 1'b0, "wr512");
    for (int i = 0; i < 512; i++) rexp[i] = 128'(i);
    applyRead(32'h0, 512, 1'b0, -1, "rd512");

    $display("[TB] read backpressure over 8 beats");
    applyRead(32'h0, 8, 1'b1, -1, "rdbp");

    $display("[TB] write wrapping past the top word");
    wvec[0] = 128'hA0A0_0000_0000_0000_0000_0000_0000_000A;
    wvec[1] = 128'hB0B0_0000_0000_0000_0000_0000_0000_000B;
    wvec[2] = 128'hC0C0_0000_0000_0000_0000_0000_0000_000C;
    wvec[3] = 128'hD0D0_0000_0000_0000_0000_0000_0000_000D;
    applyWrite(32'h0001_FFF0, 4, -1, 0, 1'b0, "wrwrap");
    for (int i = 0; i < 3; i++) rexp[i] = wvec[i + 1];
    applyRead(32'h0, 3, 1'b0, -1, "rdwrap0");
    for (int i = 0; i < 4; i++) rexp[i] = wvec[i];
    applyRead(32'h0000_FFF0, 4, 1'b0, -1, "rdwraptop");

    $display("[TB] write throttled by wready mid-burst");
    for (int i = 0; i < 16; i++) wvec[i] = 128'hFEED_0000_1234_5678_0000_0000_0000_0000 + 128'(i);
    applyWrite(32'h2000, 16, 7, 3, 1'b0, "wrthr");
    for (int i = 0; i < 16; i++) rexp[i] = wvec[i];
    applyRead(32'h2000, 16, 1'b0, -1, "rdthr");

    $display("[TB] simultaneous write and read requests");
    for (int i = 0; i < 4; i++) wvec[i] = 128'h5A5A_0000_0000_0000_0000_0000_0000_0000 + 128'(i);
    fdma_raddr = 32'h2000;
    fdma_rsize = 16'd2;
    applyWrite(32'h3000, 4, -1, 0, 1'b1, "wrsim");
    applyRead(32'h2000, 2, 1'b0, -1, "rdsim");

    $display("[TB] zero-length bursts");
    applyWrite(32'h3000, 0, -1, 0, 1'b0, "wrzero");
    for (int i = 0; i < 4; i++) rexp[i] = 128'h5A5A_0000_0000_0000_0000_0000_0000_0000 + 128'(i);
    applyRead(32'h3000, 4, 1'b0, -1, "rdsimchk");
    applyRead(32'h3000, 0, 1'b0, -1, "rdzero");

    $display("[TB] reset during a read burst");
    for (int i = 0; i < 16; i++) rexp[i] = 128'(16 + i);
    applyRead(32'h100, 16, 1'b0, 5, "rdabort");
    applyRead(32'h10F, 16, 1'b0, -1, "rdafter");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdma_bram_slave.md
Name: fdma_bram_slave

Overview:
- FDMA responder backed by on-chip block RAM. It accepts write and read burst requests from an FDMA initiator and serves them through the standard fdma_w*/fdma_r* handshake.
- Stands in for the FDMA-to-AXI DDR path in simulation and in DDR-less bring-up, so FDMA initiators (test drivers, video writers/readers) can run against it unchanged.
- Single-port memory: one burst is in service at a time.

Parameters:
- DATA_W, 128, FDMA data width in bits; must be a power of two and at least 8.
- AW, 12, log2 of memory depth in words (default 4096 x 128 bit = 64 KiB).
- BYTE_LSB, 4, equal to log2(DATA_W/8); byte-address bits ignored when forming the word index.

Ports:
- ui_clk  in  1  clock.
- ui_rst  in  1  synchronous reset, active-high.
- fdma_waddr  in  32  write burst start byte address.
- fdma_wareq  in  1  write request; held by initiator until it sees fdma_wbusy.
- fdma_wsize  in  16  write burst length in beats.
- fdma_wbusy  out  1  write burst in progress.
- fdma_wvalid  out  1  beat strobe; fdma_wdata is sampled in the same cycle.
- fdma_wready  in  1  initiator can supply data.
- fdma_wdata  in  DATA_W  write data.
- fdma_raddr  in  32  read burst start byte address.
- fdma_rareq  in  1  read request.
- fdma_rsize  in  16  read burst length in beats.
- fdma_rbusy  out  1  read burst in progress.
- fdma_rvalid  out  1  fdma_rdata valid.
- fdma_rready  in  1  initiator accepts a beat.
- fdma_rdata  out  DATA_W  read data.

Behaviour:
- Reset values: fdma_wbusy=0, fdma_rbusy=0, fdma_wvalid=0, fdma_rvalid=0, fdma_rdata=0, state IDLE, read buffer empty. Memory contents are not reset; they are zero at configuration.
- States: IDLE, WR, RD, DONE.
- IDLE
  - fdma_wareq=1 in cycle T: latch waddr and wsize; WR from T+1 with fdma_wbusy=1.
  - fdma_rareq=1 (and no fdma_wareq): latch raddr and rsize; RD from T+1 with fdma_rbusy=1.
  - Both asserted in the same cycle: write wins; rareq stays pending and is served after DONE.
- Word index = addr[BYTE_LSB +: AW]. Bits below BYTE_LSB are ignored. The index increments by 1 per beat and wraps modulo 2^AW; bits above are ignored.
- WR
  - fdma_wvalid = (state==WR) && beats_left!=0 && fdma_wready. This is combinational from registered state.
  - Each wvalid cycle writes fdma_wdata to mem[idx], then idx+1 and beats_left-1.
  - After the final beat, DONE.
- RD
  - 2-entry output buffer.
  - A memory read is issued in any cycle with reads_left!=0 and buffer space, counting entries in flight plus occupied.
  - BRAM latency is 1 cycle.
  - fdma_rvalid = buffer non-empty. A beat transfers on fdma_rvalid && fdma_rready.
  - fdma_rdata is stable while fdma_rvalid && !fdma_rready.
  - With fdma_rready held at 1: first fdma_rvalid at T+2, then 1 beat/cycle.
  - After the last beat transfers, DONE.
- DONE: deasserts fdma_wbusy/fdma_rbusy for one cycle, then IDLE. Busy therefore falls the cycle after the last beat.
  - Requests present in DONE are ignored and sampled in IDLE. An initiator holding its request is served next.
- Size 0: busy is high for exactly one cycle (WR/RD immediately to DONE), with no beats and no memory access.
- Exactly fdma_wsize wvalid pulses and fdma_rsize rvalid transfers per burst. No extra beats.
- Requests arriving while busy are not latched.
- Reset mid-burst: next cycle all outputs return to reset values and the buffer is flushed. Words already written remain in memory.

Optional Feature:
- Macro FDMA_SLV_STATS_EN.
- When defined:
  - Extra output ports stat_wr_bursts (32), stat_rd_bursts (32), stat_beats (32).
  - Each counter increments in DONE (bursts, by type) or per transferred beat (beats), including size-0 bursts.
  - Counters saturate at 0xFFFFFFFF and clear on ui_rst.
- When undefined: these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
- Write waddr=0x0, wsize=512, wready=1, wdata=beat count 0..511 → 512 wvalid pulses, wbusy falls 1 cycle after beat 511. Then read raddr=0x0, rsize=512, rready=1 → first rvalid at T+2, rdata[15:0]=0..511 with no gaps, rbusy falls after beat 511.
- Wrap: write waddr=0xFFF0, wsize=4, data A,B,C,D → words 4095,0,1,2. Read raddr=0x0, rsize=3 → B,C,D.
- Read backpressure: rready toggling 1,0,0,1 repeatedly over 8 beats → rdata held while stalled, order 0..7 preserved, exactly 8 transfers.
- Write throttle: wready low for 3 cycles mid-burst of 16 → wvalid low in those cycles, 16 beats total, read-back matches.
- Simultaneous wareq and rareq (both held) → write burst served first, read starts after DONE. Size-0 write → wbusy high exactly 1 cycle, memory unchanged.
- ui_rst asserted at beat 5 of a 16-beat read → next cycle rvalid=0 and rbusy=0. A new read of the same address returns correct data from beat 0.
